// File: rtl/bsg_comm_link_pkg.sv
// rtl/bsg_comm_link_pkg.sv - shared link widths and transmit FSM state encoding
package bsg_comm_link_pkg;

    localparam int BEAT_W = 8;
    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2
    } tx_state_e;

endpackage

// File: rtl/bsg_tx_fifo.sv
// rtl/bsg_tx_fifo.sv - word FIFO with wrap-bit pointers for full/empty detection
module bsg_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             do_push, do_pop;

    // Equal index with differing wrap bit means every slot is occupied.
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign count_o = wptr_q - rptr_q;
    assign head_o  = mem_q[rptr_q[AW-1:0]];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign wptr_d  = do_push ? (wptr_q + PTR_ONE) : wptr_q;
    assign rptr_d  = do_pop  ? (rptr_q + PTR_ONE) : rptr_q;

    // Pointer registers; reset empties the FIFO by realigning both pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage array; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/bsg_upstream_ch_tx.sv
// rtl/bsg_upstream_ch_tx.sv - credit-based upstream transmitter, 16-bit words as 8-bit beats
module bsg_upstream_ch_tx
    import bsg_comm_link_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int CREDITS     = 16,
    parameter int TOKEN_RATIO = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             core_valid_i,
    input  logic [WORD_W-1:0]                core_data_i,
    output logic                             core_ready_o,
    output logic                             io_valid_o,
    output logic [BEAT_W-1:0]                io_data_o,
    input  logic                             io_token_i,
    output logic [$clog2(CREDITS+1)-1:0]     credit_o,
    output logic                             credit_err_o
);

    localparam int CW = $clog2(CREDITS + 1);
    localparam int SW = CW + 1;
    localparam int PW = $clog2(DEPTH) + 1;
    localparam logic [PW-1:0] CNT_ONE = PW'(1);

    tx_state_e         state_q, state_d;
    logic [CW-1:0]     credit_q, credit_d;
    logic [SW-1:0]     credit_sum;
    logic              tok_q, tok_rise;
    logic              err_q, err_d;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [WORD_W-1:0] fifo_head;
    logic [PW-1:0]     fifo_count;
    logic              enter_lo, have_credit;

    // Ready is forced low while reset is held so nothing is accepted then.
    assign core_ready_o = rst & ~fifo_full;
    assign fifo_push    = core_valid_i & core_ready_o;
    assign have_credit  = (credit_q != '0);
    assign tok_rise     = io_token_i & ~tok_q;
    assign credit_o     = credit_q;
    assign credit_err_o = err_q;

    bsg_tx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .push_i  (fifo_push),
        .data_i  (core_data_i),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Beat sequencer: low byte then high byte, popping the word at the end of HI.
    always_comb begin
        state_d    = state_q;
        fifo_pop   = 1'b0;
        enter_lo   = 1'b0;
        io_valid_o = 1'b0;
        io_data_o  = '0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && have_credit) begin
                    state_d  = ST_LO;
                    enter_lo = 1'b1;
                end
            end
            ST_LO: begin
                io_valid_o = 1'b1;
                io_data_o  = fifo_head[BEAT_W-1:0];
                state_d    = ST_HI;
            end
            ST_HI: begin
                io_valid_o = 1'b1;
                io_data_o  = fifo_head[WORD_W-1:BEAT_W];
                fifo_pop   = 1'b1;
                // A second stored word keeps the link busy without an idle gap.
                if ((fifo_count > CNT_ONE) && have_credit) begin
                    state_d  = ST_LO;
                    enter_lo = 1'b1;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Credit update: token adds a batch, each word start spends one; clamp and flag overflow.
    always_comb begin
        credit_sum = {1'b0, credit_q};
        if (tok_rise) begin
            credit_sum = credit_sum + SW'(TOKEN_RATIO);
        end
        if (enter_lo) begin
            credit_sum = credit_sum - SW'(1);
        end
        credit_d = credit_sum[CW-1:0];
        err_d    = err_q;
        if (credit_sum > SW'(CREDITS)) begin
            credit_d = CW'(CREDITS);
            err_d    = 1'b1;
        end
    end

    // State, credit, token history and sticky error registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            credit_q <= CW'(CREDITS);
            tok_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            tok_q    <= io_token_i;
            err_q    <= err_d;
        end
    end

endmodule

// File: doc/bsg_upstream_ch_tx.md
BSG_UPSTREAM_CH_TX -- requirements
Module: bsg_upstream_ch_tx

Interface
REQ-001 The module SHALL have parameter DEPTH, default 8, meaning FIFO depth in 16-bit words (power of 2, >=2).
REQ-002 The module SHALL have parameter CREDITS, default 16, meaning initial and maximum word credits granted by the far-end receiver.
REQ-003 The module SHALL have parameter TOKEN_RATIO, default 4, meaning words returned per io_token_i rising edge.
REQ-004 The module SHALL use one clock; reset is asynchronous and active-low.
REQ-005 The module SHALL have port clk, input, 1 bit: the single io clock; all state samples on its rising edge.
REQ-006 The module SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 The module SHALL have port core_valid_i, input, 1 bit: core offers a word.
REQ-008 The module SHALL have port core_data_i, input, 16 bits: offered word.
REQ-009 The module SHALL have port core_ready_o, output, 1 bit: FIFO not full; word accepted when core_valid_i & core_ready_o.
REQ-010 The module SHALL have port io_valid_o, output, 1 bit: a byte is on the link this cycle.
REQ-011 The module SHALL have port io_data_o, output, 8 bits: link byte.
REQ-012 The module SHALL have port io_token_i, input, 1 bit: credit-return token, already synchronous to clk.
REQ-013 The module SHALL have port credit_o, output, clog2(CREDITS+1) bits: current credit count.
REQ-014 The module SHALL have port credit_err_o, output, 1 bit: sticky credit-overflow flag.

Function
REQ-015 Accepted words SHALL be written into the FIFO at the accepting edge and SHALL become visible at the head on the next cycle.
REQ-016 core_ready_o SHALL equal not-full, independent of core_valid_i, and SHALL deassert on the cycle the FIFO holds DEPTH words.
REQ-017 A push to a full FIFO SHALL be ignored, with no data change.
REQ-018 The FSM SHALL have states IDLE, LO and HI.
REQ-019 In IDLE, when the FIFO is non-empty and credit_o>0, the FSM SHALL go to LO; otherwise it SHALL stay in IDLE.
REQ-020 In LO, io_valid_o SHALL be 1 and io_data_o SHALL be head[7:0]; the next state SHALL be HI unconditionally.
REQ-021 In HI, io_valid_o SHALL be 1 and io_data_o SHALL be head[15:8]; the head SHALL pop at the end of HI.
REQ-022 From HI, the FSM SHALL go to LO if, after the pop, a further word is present and credit_o>0; otherwise it SHALL go to IDLE. Back-to-back words therefore give continuous valid beats.
REQ-023 In IDLE, io_valid_o SHALL be 0 and io_data_o SHALL be 8'h00.
REQ-024 Latency: a word pushed at edge t into an empty FIFO, with credit available, SHALL produce its LO beat in cycle t+2.
REQ-025 Credit SHALL decrement by 1 on every transition into LO.
REQ-026 A rising edge of io_token_i (detected against a registered copy) SHALL add TOKEN_RATIO to credit.
REQ-027 When a token and a decrement occur in the same cycle, credit SHALL change by the net amount TOKEN_RATIO-1.
REQ-028 If an addition would exceed CREDITS, credit SHALL saturate at CREDITS and credit_err_o SHALL set; credit_err_o SHALL clear only on reset.
REQ-029 With credit_o==0 and data pending, the FSM SHALL hold IDLE; any word already in LO SHALL complete its HI beat.
REQ-030 FIFO read and write pointers SHALL wrap modulo DEPTH, with an extra MSB to distinguish full from empty.
REQ-031 A simultaneous push and pop on a full FIFO SHALL be refused for the push, since core_ready_o was 0.
REQ-032 A simultaneous push and pop on a non-full FIFO SHALL keep the occupancy unchanged.

Reset
REQ-033 On rst low, the module SHALL immediately clear the FSM to IDLE, the FIFO pointers to 0, the token register to 0, credit_err_o to 0 and credit_o to CREDITS.
REQ-034 While rst is low, io_valid_o SHALL be 0, io_data_o SHALL be 8'h00 and core_ready_o SHALL be 0.
REQ-035 Reset asserted mid-word SHALL abort the word and discard all FIFO contents.
REQ-036 Reset deassertion SHALL take effect at the next rising clk edge.

Structure
REQ-037 The FSM state enum, the beat-width constant (8) and the word-width constant (16) SHALL live in a shared package bsg_comm_link_pkg.
REQ-038 The FIFO SHALL be a separate sub-module, bsg_tx_fifo, parameterised by DEPTH and width; the FSM and credit counter SHALL stay in the top.

Verification
REQ-039 Single word: push 16'hA55A into an idle block with credit 16 -> io beats 8'h5A then 8'hA5 in cycles t+2 and t+3, and credit_o reads 15.
REQ-040 Credit stall: hold io_token_i low and push 17 words (back-pressure on) -> exactly 16 words (32 beats) sent; FSM then sits in IDLE with credit_o==0; one token edge -> 4 more beats pairs begin, credit_o reaches 3 after the first.
REQ-041 FIFO full: block the link (credit 0) and push 9 words -> core_ready_o drops after the 8th word, the 9th is not accepted, and no data is corrupted after credit is restored.
REQ-042 Simultaneous events: token edge in the same cycle as an IDLE->LO transition at credit 1 -> credit becomes 4, with no error.
REQ-043 Overflow: token edge at credit 14 -> credit_o==16 and credit_err_o==1, sticky until reset.
REQ-044 Reset mid-word: assert rst during the HI beat -> io_valid_o drops the same cycle; after release, credit_o==16, core_ready_o==1 and no stale word is sent.
